mips_instr_encoder: RTL and testbench

//  Packs symbolic instruction requests (op class + register/immediate fields) into 32-bit MIPS words
//  for the add/sub/ori/lw/sw/beq/lui/jal/jr subset. Buffers them in a small FIFO and writes them

---
 rtl/mips_isa_pkg.sv | 67 ++++++
 rtl/mips_instr_encoder_if.sv | 31 +++
 rtl/mips_instr_encoder_fifo.sv | 49 ++++
 rtl/mips_instr_encoder.sv | 130 +++++++++++++
 tb/tb_mips_instr_encoder.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: op-class enum, opcodes/functs, encoder state.
// Also holds the word encoder used by the program loader.
package mips_isa_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_ORI = 4'd2,
        OP_LW  = 4'd3,
        OP_SW  = 4'd4,
        OP_BEQ = 4'd5,
        OP_LUI = 4'd6,
        OP_JAL = 4'd7,
        OP_JR  = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } enc_state_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] FN_ADD    = 6'h20;
    localparam logic [5:0] FN_SUB    = 6'h22;
    localparam logic [5:0] FN_JR     = 6'h08;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_3000;

    function automatic logic op_legal(logic [3:0] op);
        return op <= 4'd8;
    endfunction

    // Unknown op classes fall through to an all-zero word (sll $0 = nop).
    function automatic logic [31:0] encode(
        logic [3:0]  op,
        logic [4:0]  rs,
        logic [4:0]  rt,
        logic [4:0]  rd,
        logic [15:0] imm,
        logic [25:0] tgt
    );
        logic [31:0] w;
        w = '0;
        case (op)
            OP_ADD: w = {OPC_RTYPE, rs, rt, rd, 5'h0, FN_ADD};
            OP_SUB: w = {OPC_RTYPE, rs, rt, rd, 5'h0, FN_SUB};
            OP_ORI: w = {OPC_ORI, rs, rt, imm};
            OP_LW:  w = {OPC_LW, rs, rt, imm};
            OP_SW:  w = {OPC_SW, rs, rt, imm};
            OP_BEQ: w = {OPC_BEQ, rs, rt, imm};
            OP_LUI: w = {OPC_LUI, 5'h0, rt, imm};
            OP_JAL: w = {OPC_JAL, tgt};
            OP_JR:  w = {OPC_RTYPE, rs, 15'h0, FN_JR};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Request bus (valid/ready + instruction fields) and IM write bus.
// master: request source / IM sink side; slave: the encoder.
interface mips_instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              im_ready;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd,
        output in_imm, in_target, in_last, im_ready,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd,
        input  in_imm, in_target, in_last, im_ready,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/mips_instr_encoder_fifo.sv
// instr_fifo: synchronous FIFO of encoded words + last flag.
// Ports: clk, reset, flush, push/din, pop/dout, full, empty.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    // Extra pointer bit separates full from empty.
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) begin
                mem[wp[AW-1:0]] <= din;
                wp <= wp + 1'b1;
            end
            if (pop && !empty) begin
                rp <= rp + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes requests, buffers them, writes IM from BASE_ADDR.
// Ports: clk, reset, start, bus (slave), count, done, err. Option: ENC_ILLEGAL_TRAP_EN.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF),
    parameter int                MAX_WORDS = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    mips_instr_encoder_if.slave        bus,
    output logic [15:0]                count,
    output logic                       done,
    output logic                       err
);
    enc_state_e        state;
    enc_state_e        state_nx;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              accept;
    logic              cap;
    logic              ovf;
    logic              drain_fin;
    logic [32:0]       head;
    logic [31:0]       word;
    logic [ADDR_W-1:0] addr_q;

    assign word = encode(bus.in_op, bus.in_rs, bus.in_rt,
                         bus.in_rd, bus.in_imm, bus.in_target);

    assign cap = (count == 16'(MAX_WORDS));
    // FIFO only holds data in RUN/DRAIN, so pending data at cap is overflow.
    assign ovf = cap && !empty;

    // No accept while restarting or overflowing: it would be flushed.
    assign bus.in_ready = (state == S_RUN) && !full && !start && !ovf;
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef ENC_ILLEGAL_TRAP_EN
    logic legal;
    assign legal = op_legal(bus.in_op);
    assign push  = accept && legal;
`else
    assign push  = accept;
`endif

    assign bus.im_we    = !empty && !cap;
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = empty ? 32'h0 : head[31:0];
    assign pop          = bus.im_we && bus.im_ready;

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (33)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (start || ovf),
        .push  (push),
        .din   ({bus.in_last, word}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx  = state;
        drain_fin = 1'b0;
        if (start) begin
            state_nx = S_RUN;
        end else if (ovf) begin
            state_nx = S_DONE;
        end else begin
            case (state)
                S_IDLE: state_nx = S_IDLE;
                S_RUN: begin
                    if (accept && bus.in_last) begin
                        state_nx = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Empty covers a trapped last request.
                    if (empty || (pop && head[32])) begin
                        state_nx  = S_DONE;
                        drain_fin = 1'b1;
                    end
                end
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            addr_q <= BASE_ADDR;
            count  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= drain_fin;
            if (start) begin
                addr_q <= BASE_ADDR;
                count  <= '0;
                err    <= 1'b0;
            end else begin
                if (pop) begin
                    addr_q <= addr_q + ADDR_W'(4);
                    count  <= count + 16'd1;
                end
                if (ovf) begin
                    err <= 1'b1;
                end
`ifdef ENC_ILLEGAL_TRAP_EN
                if (accept && !legal) begin
                    err <= 1'b1;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized self-checking bench for mips_instr_encoder.
// Scoreboard of expected IM words; second instance with MAX_WORDS=2.
module tb_mips_instr_encoder;

    typedef struct {
        int op;
        int rs;
        int rt;
        int rd;
        int imm;
        int tgt;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cstart = 1'b0;
    logic [15:0] count;
    logic [15:0] ccount;
    logic        done;
    logic        cdone;
    logic        err;
    logic        cerr;

    int total = 0;
    int bad = 0;
    int ready_mode = 0;
    int done_cnt = 0;
    int cdone_cnt = 0;
    int cwr = 0;
    int wr_idx = 0;
    logic [31:0] expq[$];

    mips_instr_encoder_if bus ();
    mips_instr_encoder_if cbus ();

    assign cbus.in_valid  = bus.in_valid;
    assign cbus.in_op     = bus.in_op;
    assign cbus.in_rs     = bus.in_rs;
    assign cbus.in_rt     = bus.in_rt;
    assign cbus.in_rd     = bus.in_rd;
    assign cbus.in_imm    = bus.in_imm;
    assign cbus.in_target = bus.in_target;
    assign cbus.in_last   = bus.in_last;
    assign cbus.im_ready  = 1'b1;

    mips_instr_encoder u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .count (count),
        .done  (done),
        .err   (err)
    );

    mips_instr_encoder #(
        .MAX_WORDS (2)
    ) u_cap (
        .clk   (clk),
        .reset (reset),
        .start (cstart),
        .bus   (cbus),
        .count (ccount),
        .done  (cdone),
        .err   (cerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference encoding straight from the field layout, by arithmetic.
    function automatic logic [31:0] ref_word(req_t r);
        longint w;
        longint p26 = 64'd67108864;
        longint p21 = 64'd2097152;
        longint p16 = 64'd65536;
        longint p11 = 64'd2048;
        case (r.op)
            0: w = r.rs * p21 + r.rt * p16 + r.rd * p11 + 32;
            1: w = r.rs * p21 + r.rt * p16 + r.rd * p11 + 34;
            2: w = 13 * p26 + r.rs * p21 + r.rt * p16 + r.imm;
            3: w = 35 * p26 + r.rs * p21 + r.rt * p16 + r.imm;
            4: w = 43 * p26 + r.rs * p21 + r.rt * p16 + r.imm;
            5: w = 4 * p26 + r.rs * p21 + r.rt * p16 + r.imm;
            6: w = 15 * p26 + r.rt * p16 + r.imm;
            7: w = 3 * p26 + r.tgt;
            8: w = r.rs * p21 + 8;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.op  = int'($urandom_range(0, 8));
        r.rs  = int'($urandom_range(0, 31));
        r.rt  = int'($urandom_range(0, 31));
        r.rd  = int'($urandom_range(0, 31));
        r.imm = int'($urandom_range(0, 65535));
        r.tgt = int'($urandom_range(0, 32'h3FF_FFFF));
        return r;
    endfunction

    function automatic req_t mk(int op, int rs, int rt, int rd,
                                int imm, int tgt);
        req_t r;
        r.op  = op;
        r.rs  = rs;
        r.rt  = rt;
        r.rd  = rd;
        r.imm = imm;
        r.tgt = tgt;
        return r;
    endfunction

    task automatic model_push(req_t r);
`ifdef ENC_ILLEGAL_TRAP_EN
        if (r.op <= 8) expq.push_back(ref_word(r));
`else
        expq.push_back(ref_word(r));
`endif
    endtask

    task automatic drive(req_t r, bit last);
        bus.in_op     = 4'(r.op);
        bus.in_rs     = 5'(r.rs);
        bus.in_rt     = 5'(r.rt);
        bus.in_rd     = 5'(r.rd);
        bus.in_imm    = 16'(r.imm);
        bus.in_target = 26'(r.tgt);
        bus.in_last   = last;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(bit c, req_t r, bit last);
        int  n = 0;
        bit  ok = 0;
        drive(r, last);
        bus.in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (c ? cbus.in_ready : bus.in_ready) begin
                ok = 1;
                if (!c) model_push(r);
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("accept", 64'(ok), 64'd1);
    endtask

    task automatic pulse_start(bit c);
        if (c) cstart = 1'b1;
        else start = 1'b1;
        @(posedge clk);
        #1;
        cstart = 1'b0;
        start  = 1'b0;
        if (!c) wr_idx = 0;
    endtask

    task automatic wait_done();
        int b = done_cnt;
        for (int i = 0; i < 500 && done_cnt == b; i++) begin
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulse", 64'(done_cnt - b), 64'd1);
    endtask

    task automatic run_prog(input req_t q[$], input bit lat);
        int n = 0;
        bit e = 0;
        pulse_start(0);
        foreach (q[i]) begin
            if (q[i].op <= 8) n++;
            else begin
`ifdef ENC_ILLEGAL_TRAP_EN
                e = 1;
`else
                n++;
`endif
            end
            send(0, q[i], i == q.size() - 1);
            if (lat && i == 0) begin
                @(negedge clk);
                chk("latency_we", 64'(bus.im_we), 64'd1);
                @(posedge clk);
                #1;
            end
        end
        wait_done();
        chk("count", 64'(count), 64'(n));
        chk("err", 64'(err), 64'(e));
        chk("drained", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        bus.im_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.im_ready = 1'b1;
                1: bus.im_ready = 1'b0;
                default: bus.im_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Write monitor: every IM write is matched against the scoreboard.
    initial begin
        bit          pstall = 0;
        logic [31:0] paddr = '0;
        logic [31:0] pdata = '0;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (done) done_cnt++;
                if (cdone) cdone_cnt++;
                if (cbus.im_we && cbus.im_ready) cwr++;
                if (pstall && bus.im_we) begin
                    chk("hold_addr", 64'(bus.im_addr), 64'(paddr));
                    chk("hold_data", 64'(bus.im_wdata), 64'(pdata));
                end
                pstall = bus.im_we && !bus.im_ready;
                paddr  = bus.im_addr;
                pdata  = bus.im_wdata;
                if (bus.im_we && bus.im_ready) begin
                    chk("write_expected", 64'(expq.size() != 0), 64'd1);
                    if (expq.size() != 0) begin
                        w = expq.pop_front();
                        chk("wdata", 64'(bus.im_wdata), 64'(w));
                        chk("waddr", 64'(bus.im_addr),
                            64'(32'h3000 + 4 * wr_idx));
                    end
                    wr_idx++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t q[$];
        req_t sr[6];
        int   acc;

        bus.in_valid = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0), 1'b0);
        #12;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_im_we", 64'(bus.im_we), 64'd0);
        chk("rst_im_addr", 64'(bus.im_addr), 64'h3000);
        chk("rst_im_wdata", 64'(bus.im_wdata), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'd0);

        q = {};
        q.push_back(mk(0, 1, 2, 3, 0, 0));
        run_prog(q, 1);

        q = {};
        q.push_back(mk(2, 0, 1, 0, 16'h1234, 0));
        q.push_back(mk(6, 0, 2, 0, 16'hFFFF, 0));
        q.push_back(mk(7, 0, 0, 0, 0, 26'h0C00));
        run_prog(q, 0);

        q = {};
        q.push_back(mk(4, 0, 2, 0, 4, 0));
        q.push_back(mk(5, 1, 2, 0, 16'hFFFF, 0));
        q.push_back(mk(8, 31, 0, 0, 0, 0));
        run_prog(q, 0);

        // Stalled IM: only DEPTH requests fit; the rest wait.
        ready_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        foreach (sr[i]) sr[i] = rand_req();
        pulse_start(0);
        acc = 0;
        drive(sr[0], 1'b0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model_push(sr[acc]);
                acc++;
            end
            @(posedge clk);
            #1;
            if (acc < 6) drive(sr[acc], acc == 5);
        end
        chk("stall_accepts", 64'(acc), 64'd4);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_count", 64'(count), 64'd0);
        bus.in_valid = 1'b0;
        ready_mode = 0;
        for (int k = acc; k < 6; k++) send(0, sr[k], k == 5);
        wait_done();
        chk("stall_total", 64'(count), 64'd6);
        chk("stall_drained", 64'(expq.size()), 64'd0);

        ready_mode = 2;
        for (int p = 0; p < 4; p++) begin
            int len = int'($urandom_range(1, 12));
            q = {};
            for (int k = 0; k < len; k++) q.push_back(rand_req());
            run_prog(q, 0);
        end
        ready_mode = 0;

        q = {};
        q.push_back(mk(15, 3, 4, 5, 16'h00FF, 0));
        run_prog(q, 0);
        pulse_start(0);
        chk("start_clears_err", 64'(err), 64'd0);
        chk("start_clears_cnt", 64'(count), 64'd0);
        q = {};
        q.push_back(mk(1, 7, 8, 9, 0, 0));
        run_prog(q, 0);

        // Capacity overflow on the MAX_WORDS=2 instance.
        pulse_start(1);
        cwr = 0;
        cdone_cnt = 0;
        for (int k = 0; k < 3; k++) send(1, rand_req(), k == 2);
        repeat (10) @(posedge clk);
        #1;
        chk("cap_writes", 64'(cwr), 64'd2);
        chk("cap_err", 64'(cerr), 64'd1);
        chk("cap_no_done", 64'(cdone_cnt), 64'd0);
        chk("cap_count", 64'(ccount), 64'd2);
        chk("cap_we_off", 64'(cbus.im_we), 64'd0);
        chk("cap_in_ready", 64'(cbus.in_ready), 64'd0);
        pulse_start(1);
        chk("cap_err_clr", 64'(cerr), 64'd0);
        chk("cap_cnt_clr", 64'(ccount), 64'd0);
        chk("cap_addr_rst", 64'(cbus.im_addr), 64'h3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
